// File: rtl/nor2_stim_checker_pkg.sv
// Shared types and helpers for the NOR2 stimulus/response checker.
package nor2_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  typedef logic [1:0] vec_t;

  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned PASS_W   = 8;

  // Golden response of the cell for a {A,B} input vector.
  function automatic logic exp_nor(input vec_t vec);
    return ~(vec[1] | vec[0]);
  endfunction

endpackage

// File: rtl/nor2_stim_checker_if.sv
// Signal bundle between the checker (master) and the cell/host side (slave).
// NOR2_XCHK_EN adds the xz_seen status flag.
interface nor2_stim_checker_if
  import nor2_chk_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
);

  logic                 start;
  logic                 dut_a;
  logic                 dut_b;
  logic                 dut_y;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [ERR_CNT_W-1:0] err_cnt;
  vec_t                 first_err_vec;
`ifdef NOR2_XCHK_EN
  logic                 xz_seen;
`endif

  modport master (
    input  start,
    input  dut_y,
    output dut_a,
    output dut_b,
    output busy,
    output done,
    output pass,
    output err_cnt,
    output first_err_vec
`ifdef NOR2_XCHK_EN
    , output xz_seen
`endif
  );

  modport slave (
    output start,
    output dut_y,
    input  dut_a,
    input  dut_b,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt,
    input  first_err_vec
`ifdef NOR2_XCHK_EN
    , input xz_seen
`endif
  );

endinterface

// File: rtl/nor2_stim_checker.sv
// Sweeps a 2-input NOR cell through 00,01,10,11, samples Y after a settle time
// and counts mismatches. NOR2_XCHK_EN enables X/Z tracking on dut_y.
module nor2_stim_checker
  import nor2_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_PASSES    = 1,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  nor2_stim_checker_if.master bus
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0]   LAST_PASS   = PASS_W'(NUM_PASSES - 1);

  state_e               state_q, state_d;
  vec_t                 vec_q, vec_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic [PASS_W-1:0]    passes_q, passes_d;
  logic                 a_q, a_d;
  logic                 b_q, b_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  vec_t                 first_q, first_d;
  logic                 mismatch_c;
`ifdef NOR2_XCHK_EN
  logic                 xz_q, xz_d;
  logic                 y_unknown_c;

  // X/Z counts as a miss: case inequality never yields X.
  assign y_unknown_c = $isunknown(bus.dut_y);
  assign mismatch_c  = (bus.dut_y !== exp_nor({a_q, b_q}));
`else
  // Plain inequality: an X sample evaluates unknown and is not counted.
  assign mismatch_c  = (bus.dut_y != exp_nor({a_q, b_q}));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      passes_q <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      first_q  <= '0;
`ifdef NOR2_XCHK_EN
      xz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      passes_q <= passes_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      first_q  <= first_d;
`ifdef NOR2_XCHK_EN
      xz_q     <= xz_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    passes_d = passes_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    first_d  = first_q;
`ifdef NOR2_XCHK_EN
    xz_d     = xz_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = DRIVE;
          vec_d    = '0;
          passes_d = '0;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          err_d    = '0;
          first_d  = '0;
`ifdef NOR2_XCHK_EN
          xz_d     = 1'b0;
`endif
        end
      end
      DRIVE: begin
        a_d      = vec_q[1];
        b_d      = vec_q[0];
        settle_d = SETTLE_LOAD;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      SAMPLE: begin
`ifdef NOR2_XCHK_EN
        if (y_unknown_c) begin
          xz_d = 1'b1;
        end
`endif
        if (mismatch_c) begin
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end
          if (err_q == '0) begin
            first_d = {a_q, b_q};
          end
        end
        // Last vector of a sweep either closes the run or restarts at 00.
        if (vec_q == 2'b11) begin
          passes_d = passes_q + 1'b1;
          if (passes_q == LAST_PASS) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d   = '0;
            state_d = DRIVE;
          end
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef NOR2_XCHK_EN
  // Flags an X/Z response so it is visible in the log, not just in err_cnt.
  always @(posedge clk) begin
    if (rst_n && state_q == SAMPLE) begin
      assert (!y_unknown_c)
        else $error("nor2_stim_checker: X/Z on dut_y for vector %b", {a_q, b_q});
    end
  end

  assign bus.xz_seen = xz_q;
`endif

  assign bus.dut_a         = a_q;
  assign bus.dut_b         = b_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_q;
  assign bus.first_err_vec = first_q;

endmodule

// File: tb/tb_nor2_stim_checker.sv
// Directed bench for nor2_stim_checker: a behavioural cell model with selectable
// faults drives dut_y. Two instances cover the default and a 3-pass/2-bit build.
module tb_nor2_stim_checker;

  logic clk;
  logic rst_n;
  int   mode0;
  int   mode1;
  int   n_vec;
  int   n_err;

  nor2_stim_checker_if #(.ERR_CNT_W(8)) bus0 ();
  nor2_stim_checker_if #(.ERR_CNT_W(2)) bus1 ();

  nor2_stim_checker #(
    .SETTLE_CYCLES(2),
    .NUM_PASSES   (1),
    .ERR_CNT_W    (8)
  ) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0.master)
  );

  nor2_stim_checker #(
    .SETTLE_CYCLES(2),
    .NUM_PASSES   (3),
    .ERR_CNT_W    (2)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1.master)
  );

  // Cell model: 0 good NOR, 1 stuck-at-0, 2 NAND, 3 stuck-at-1, 4 Z on vector 11.
  function automatic logic y_model(input int m, input logic a, input logic b);
    case (m)
      1:       return 1'b0;
      2:       return ~(a & b);
      3:       return 1'b1;
      4:       return (a & b) ? 1'bz : ~(a | b);
      default: return ~(a | b);
    endcase
  endfunction

  assign bus0.dut_y = y_model(mode0, bus0.dut_a, bus0.dut_b);
  assign bus1.dut_y = y_model(mode1, bus1.dut_a, bus1.dut_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start for one cycle and returns the cycle (start edge = 0) in which done is seen.
  task automatic run_dut(input bit sel, output int cyc);
    cyc = -1;
    @(negedge clk);
    if (sel) bus1.start = 1'b1;
    else     bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if ((sel ? bus1.done : bus0.done) === 1'b1) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_vec++; if (bus0.dut_a !== 1'b0) begin n_err++; $display("FAIL reset_dut_a got %b want 0", bus0.dut_a); end
    n_vec++; if (bus0.dut_b !== 1'b0) begin n_err++; $display("FAIL reset_dut_b got %b want 0", bus0.dut_b); end
    n_vec++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus0.busy); end
    n_vec++; if (bus0.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus0.done); end
    n_vec++; if (bus0.pass !== 1'b0) begin n_err++; $display("FAIL reset_pass got %b want 0", bus0.pass); end
    n_vec++; if (bus0.err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_err_cnt got %0d want 0", bus0.err_cnt); end
    n_vec++; if (bus0.first_err_vec !== 2'b00) begin n_err++; $display("FAIL reset_first_err got %b want 00", bus0.first_err_vec); end
    n_vec++; if (bus1.err_cnt !== 2'd0) begin n_err++; $display("FAIL reset_err_cnt1 got %0d want 0", bus1.err_cnt); end
`ifdef NOR2_XCHK_EN
    n_vec++; if (bus0.xz_seen !== 1'b0) begin n_err++; $display("FAIL reset_xz_seen got %b want 0", bus0.xz_seen); end
`endif
  endtask

  task automatic test_good_cell();
    int cyc;
    mode0 = 0;
    run_dut(1'b0, cyc);
    n_vec++; if (cyc != 17) begin n_err++; $display("FAIL good_latency got %0d want 17", cyc); end
    n_vec++; if (bus0.pass !== 1'b1) begin n_err++; $display("FAIL good_pass got %b want 1", bus0.pass); end
    n_vec++; if (bus0.err_cnt !== 8'd0) begin n_err++; $display("FAIL good_err_cnt got %0d want 0", bus0.err_cnt); end
    n_vec++; if (bus0.first_err_vec !== 2'b00) begin n_err++; $display("FAIL good_first_err got %b want 00", bus0.first_err_vec); end
    n_vec++; if ({bus0.dut_a, bus0.dut_b} !== 2'b11) begin n_err++; $display("FAIL good_ab_hold got %b want 11", {bus0.dut_a, bus0.dut_b}); end
    @(negedge clk);
    n_vec++; if (bus0.done !== 1'b0) begin n_err++; $display("FAIL good_done_pulse got %b want 0", bus0.done); end
    n_vec++; if (bus0.pass !== 1'b1) begin n_err++; $display("FAIL good_pass_held got %b want 1", bus0.pass); end
  endtask

  task automatic test_stuck0();
    int cyc;
    mode0 = 1;
    run_dut(1'b0, cyc);
    n_vec++; if (cyc != 17) begin n_err++; $display("FAIL s0_latency got %0d want 17", cyc); end
    n_vec++; if (bus0.err_cnt !== 8'd1) begin n_err++; $display("FAIL s0_err_cnt got %0d want 1", bus0.err_cnt); end
    n_vec++; if (bus0.first_err_vec !== 2'b00) begin n_err++; $display("FAIL s0_first_err got %b want 00", bus0.first_err_vec); end
    n_vec++; if (bus0.pass !== 1'b0) begin n_err++; $display("FAIL s0_pass got %b want 0", bus0.pass); end
  endtask

  task automatic test_nand();
    int cyc;
    mode0 = 2;
    run_dut(1'b0, cyc);
    n_vec++; if (bus0.err_cnt !== 8'd2) begin n_err++; $display("FAIL nand_err_cnt got %0d want 2", bus0.err_cnt); end
    n_vec++; if (bus0.first_err_vec !== 2'b01) begin n_err++; $display("FAIL nand_first_err got %b want 01", bus0.first_err_vec); end
    n_vec++; if (bus0.pass !== 1'b0) begin n_err++; $display("FAIL nand_pass got %b want 0", bus0.pass); end
  endtask

  task automatic test_saturate();
    int cyc;
    mode1 = 3;
    run_dut(1'b1, cyc);
    n_vec++; if (cyc != 49) begin n_err++; $display("FAIL sat_latency got %0d want 49", cyc); end
    n_vec++; if (bus1.err_cnt !== 2'd3) begin n_err++; $display("FAIL sat_err_cnt got %0d want 3", bus1.err_cnt); end
    n_vec++; if (bus1.first_err_vec !== 2'b01) begin n_err++; $display("FAIL sat_first_err got %b want 01", bus1.first_err_vec); end
    n_vec++; if (bus1.pass !== 1'b0) begin n_err++; $display("FAIL sat_pass got %b want 0", bus1.pass); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    mode0 = 2;
    @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (9) @(negedge clk);
    // Cycle 10: settling vector 10, one NAND miss already recorded on 01.
    n_vec++; if ({bus0.dut_a, bus0.dut_b} !== 2'b10) begin n_err++; $display("FAIL mid_ab got %b want 10", {bus0.dut_a, bus0.dut_b}); end
    n_vec++; if (bus0.err_cnt !== 8'd1) begin n_err++; $display("FAIL mid_err_cnt got %0d want 1", bus0.err_cnt); end
    n_vec++; if (bus0.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b want 1", bus0.busy); end
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if ({bus0.dut_a, bus0.dut_b} !== 2'b00) begin n_err++; $display("FAIL rst_ab got %b want 00", {bus0.dut_a, bus0.dut_b}); end
    n_vec++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", bus0.busy); end
    n_vec++; if (bus0.err_cnt !== 8'd0) begin n_err++; $display("FAIL rst_err_cnt got %0d want 0", bus0.err_cnt); end
    n_vec++; if (bus0.first_err_vec !== 2'b00) begin n_err++; $display("FAIL rst_first_err got %b want 00", bus0.first_err_vec); end
    rst_n = 1'b1;
    mode0 = 0;
    run_dut(1'b0, cyc);
    n_vec++; if (cyc != 17) begin n_err++; $display("FAIL rerun_latency got %0d want 17", cyc); end
    n_vec++; if (bus0.pass !== 1'b1) begin n_err++; $display("FAIL rerun_pass got %b want 1", bus0.pass); end
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    int done_cyc;
    bit busy_bad;
    done_cnt = 0;
    done_cyc = -1;
    busy_bad = 1'b0;
    mode0 = 0;
    @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);
    // Re-pulse start mid-run (cycle 5) and in the DONE cycle (17).
    for (int c = 1; c <= 25; c++) begin
      bus0.start = (c == 5) || (c == 17);
      if (bus0.done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c > 17 && bus0.busy !== 1'b0) busy_bad = 1'b1;
      @(negedge clk);
    end
    bus0.start = 1'b0;
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL b2b_done_count got %0d want 1", done_cnt); end
    n_vec++; if (done_cyc != 17) begin n_err++; $display("FAIL b2b_latency got %0d want 17", done_cyc); end
    n_vec++; if (busy_bad) begin n_err++; $display("FAIL b2b_restart got busy after DONE want idle"); end
    n_vec++; if (bus0.pass !== 1'b1) begin n_err++; $display("FAIL b2b_pass got %b want 1", bus0.pass); end
  endtask

`ifdef NOR2_XCHK_EN
  task automatic test_xz();
    int cyc;
    mode0 = 4;
    run_dut(1'b0, cyc);
    n_vec++; if (bus0.xz_seen !== 1'b1) begin n_err++; $display("FAIL xz_seen got %b want 1", bus0.xz_seen); end
    n_vec++; if (bus0.err_cnt !== 8'd1) begin n_err++; $display("FAIL xz_err_cnt got %0d want 1", bus0.err_cnt); end
    n_vec++; if (bus0.first_err_vec !== 2'b11) begin n_err++; $display("FAIL xz_first_err got %b want 11", bus0.first_err_vec); end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    mode0 = 0;
    mode1 = 0;
    rst_n = 1'b0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    test_reset();
    test_good_cell();
    test_stuck0();
    test_nand();
    test_saturate();
    test_reset_mid_run();
    test_back_to_back();
`ifdef NOR2_XCHK_EN
    test_xz();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
